// File: rtl/aud_recorder_if.sv
// Codec-side and SRAM-side signals of the I2S capture stage.
interface aud_recorder_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              i_lrc;
   logic              i_data;
   logic              i_start;
   logic              i_pause;
   logic              i_stop;
   logic [ADDR_W-1:0] o_address;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              o_busy;
   logic              o_full;
   logic [ADDR_W-1:0] o_last_addr;

   modport master (
      output i_lrc, i_data, i_start, i_pause, i_stop,
      input  o_address, o_data, o_valid, o_busy, o_full, o_last_addr
   );

   modport slave (
      input  i_lrc, i_data, i_start, i_pause, i_stop,
      output o_address, o_data, o_valid, o_busy, o_full, o_last_addr
   );
endinterface

// File: rtl/aud_recorder.sv
// I2S ADC capture into SRAM word writes, clocked by the codec bit clock.
// Optional AUD_REC_STEREO_EN: capture left/right to even/odd addresses.
module aud_recorder #(
   parameter int              ADDR_W   = 20,
   parameter int              DATA_W   = 16,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   aud_recorder_if.slave bus
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_EDGE, SHIFT, WRITE, PAUSED
   } state_t;

   state_t            state, state_n;
   logic              pend, pend_n;
   logic              lrc_d;
   logic              cap_edge;
   logic              pause_now;
   logic              pause_wr;
   logic              at_max;
   logic [CW-1:0]     cnt;
   logic [DATA_W-2:0] shreg;
   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] data;
   logic              full;

`ifdef AUD_REC_STEREO_EN
   // rch: the word being waited for or captured is the right channel
   logic rch;
   assign cap_edge  = rch ? (~lrc_d & bus.i_lrc) : (lrc_d & ~bus.i_lrc);
   assign pause_now = ~rch;
   assign pause_wr  = rch;
`else
   assign cap_edge  = lrc_d & ~bus.i_lrc;
   assign pause_now = 1'b1;
   assign pause_wr  = 1'b1;
`endif

   assign at_max = (address == MAX_ADDR);

   assign bus.o_address   = address;
   assign bus.o_data      = data;
   assign bus.o_valid     = (state == WRITE);
   assign bus.o_busy      = (state != IDLE);
   assign bus.o_full      = full;
   assign bus.o_last_addr = last_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         pend  <= 1'b0;
      end else begin
         state <= state_n;
         pend  <= pend_n;
      end
   end

   always_comb begin
      state_n = state;
      pend_n  = pend;
      unique case (state)
         IDLE: begin
            if (bus.i_start) state_n = WAIT_EDGE;
         end
         WAIT_EDGE: begin
            if (bus.i_pause && pause_now) begin
               state_n = PAUSED;
            end else begin
               pend_n = pend | bus.i_pause;
               if (cap_edge) state_n = SHIFT;
            end
         end
         SHIFT: begin
            pend_n = pend | bus.i_pause;
            if (cnt == LAST_BIT) state_n = WRITE;
         end
         WRITE: begin
            pend_n = pend | bus.i_pause;
            if (at_max) begin
               state_n = IDLE;
               pend_n  = 1'b0;
            end else if (pend_n && pause_wr) begin
               state_n = PAUSED;
               pend_n  = 1'b0;
            end else begin
               state_n = WAIT_EDGE;
            end
         end
         PAUSED: begin
            if (bus.i_start) state_n = WAIT_EDGE;
         end
         default: state_n = IDLE;
      endcase
      // stop outranks every other pulse and drops any partial word
      if (bus.i_stop) begin
         state_n = IDLE;
         pend_n  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lrc_d     <= 1'b1;
         cnt       <= '0;
         shreg     <= '0;
         address   <= '0;
         last_addr <= '0;
         data      <= '0;
         full      <= 1'b0;
`ifdef AUD_REC_STEREO_EN
         rch       <= 1'b0;
`endif
      end else begin
         lrc_d <= bus.i_lrc;
         if (!bus.i_stop) begin
            unique case (state)
               IDLE: begin
                  if (bus.i_start) begin
                     address <= '0;
                     full    <= 1'b0;
`ifdef AUD_REC_STEREO_EN
                     rch     <= 1'b0;
`endif
                  end
               end
               WAIT_EDGE: begin
                  if (cap_edge) cnt <= '0;
               end
               SHIFT: begin
                  shreg <= {shreg[DATA_W-3:0], bus.i_data};
                  cnt   <= cnt + CW'(1);
                  if (cnt == LAST_BIT) data <= {shreg, bus.i_data};
               end
               WRITE: begin
                  last_addr <= address;
                  if (at_max) full <= 1'b1;
                  else address <= address + ADDR_W'(1);
`ifdef AUD_REC_STEREO_EN
                  rch <= ~rch;
`endif
               end
               PAUSED: begin
`ifdef AUD_REC_STEREO_EN
                  if (bus.i_start) rch <= 1'b0;
`endif
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_aud_recorder.sv
// Randomised bench for aud_recorder against a frame-position reference model.
// Mono build; memory shrunk to four words so full is exercised often.
module tb_aud_recorder;
   localparam int FRAME = 40;
   localparam int HALF  = 20;
   localparam logic [19:0] MAXA = 20'd3;

   logic clk;
   logic rst_n;
   aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) bus ();

   aud_recorder #(
      .ADDR_W(20), .DATA_W(16), .MAX_ADDR(MAXA)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] cur_l, cur_r;
   logic [15:0] force_q[$];

   typedef enum {M_IDLE, M_RUN, M_PAUSED} mmode_t;
   mmode_t      m_mode;
   logic        m_cap, m_pend, m_full;
   logic [19:0] m_addr, m_last;
   logic [15:0] m_data;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_cap  = 1'b0;
      m_pend = 1'b0;
      m_full = 1'b0;
      m_addr = '0;
      m_last = '0;
      m_data = '0;
   endtask

   task automatic step(input logic st, input logic pa, input logic sp);
      int p;
      logic xv;
      logic [15:0] xw;
      @(negedge clk);
      p  = cyc % FRAME;
      // a captured left word is written 17 cycles after its frame edge
      xv = (m_mode == M_RUN) && m_cap && (p == 17);
      xw = xv ? cur_l : m_data;
      check("valid", bus.o_valid, xv);
      check("busy", bus.o_busy, m_mode != M_IDLE);
      check("full", bus.o_full, m_full);
      check("address", bus.o_address, m_addr);
      check("last_addr", bus.o_last_addr, m_last);
      check("data", bus.o_data, xw);
      if (p == 0) begin
         cur_l = (force_q.size() != 0) ? force_q.pop_front()
                                       : 16'($urandom);
         cur_r = 16'($urandom);
      end
      bus.i_lrc   = (p >= HALF);
      if (p >= 1 && p <= 16)       bus.i_data = cur_l[16-p];
      else if (p >= 21 && p <= 36) bus.i_data = cur_r[36-p];
      else                         bus.i_data = 1'($urandom);
      bus.i_start = st;
      bus.i_pause = pa;
      bus.i_stop  = sp;
      if (sp) begin
         m_mode = M_IDLE;
         m_cap  = 1'b0;
         m_pend = 1'b0;
      end else if (m_mode == M_RUN) begin
         if (m_cap && p == 17) begin
            m_data = cur_l;
            m_last = m_addr;
            m_cap  = 1'b0;
            if (m_addr == MAXA) begin
               m_full = 1'b1;
               m_mode = M_IDLE;
               m_pend = 1'b0;
            end else begin
               m_addr = m_addr + 1;
               if (m_pend || pa) begin
                  m_mode = M_PAUSED;
                  m_pend = 1'b0;
               end
            end
         end else if (m_cap) begin
            if (pa) m_pend = 1'b1;
         end else if (pa) begin
            m_mode = M_PAUSED;
         end else if (p == 0) begin
            m_cap = 1'b1;
         end
      end else if (st) begin
         if (m_mode == M_IDLE) begin
            m_addr = '0;
            m_full = 1'b0;
         end
         m_mode = M_RUN;
      end
      cyc++;
   endtask

   task automatic skip_to(input int tp);
      do step(1'b0, 1'b0, 1'b0);
      while (cyc % FRAME != tp);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, bus.o_valid, 1'b0);
      check({tag, "_busy"}, bus.o_busy, 1'b0);
      check({tag, "_full"}, bus.o_full, 1'b0);
      check({tag, "_addr"}, bus.o_address, 20'd0);
      check({tag, "_last"}, bus.o_last_addr, 20'd0);
      check({tag, "_data"}, bus.o_data, 16'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      bus.i_start = 1'b0;
      bus.i_pause = 1'b0;
      bus.i_stop  = 1'b0;
      bus.i_lrc   = (cyc % FRAME) >= HALF;
      #1;
      check_reset_vals("rst_mid");
      model_reset();
      cyc++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.i_lrc   = 1'b1;
      bus.i_data  = 1'b0;
      bus.i_start = 1'b0;
      bus.i_pause = 1'b0;
      bus.i_stop  = 1'b0;
      cur_l       = '0;
      cur_r       = '0;
      model_reset();
      #2;
      check_reset_vals("rst");
      #10;
      rst_n = 1'b1;

      // two left words, then a pause during the third
      repeat (35) step(1'b0, 1'b0, 1'b0);
      force_q = '{16'hA5C3, 16'h8001, 16'h1234};
      step(1'b1, 1'b0, 1'b0);
      skip_to(0);
      skip_to(0);
      skip_to(0);
      check("two_words_last", bus.o_last_addr, 20'd1);
      check("two_words_addr", bus.o_address, 20'd2);
      skip_to(8);
      step(1'b0, 1'b1, 1'b0);
      skip_to(0);
      skip_to(0);
      skip_to(15);
      check("paused_busy", bus.o_busy, 1'b1);
      check("paused_last", bus.o_last_addr, 20'd2);
      check("paused_addr", bus.o_address, 20'd3);
      step(1'b1, 1'b0, 1'b0);

      // resumed word lands on the last address and fills memory
      skip_to(0);
      skip_to(20);
      check("full_set", bus.o_full, 1'b1);
      check("full_idle", bus.o_busy, 1'b0);
      check("full_last", bus.o_last_addr, 20'd3);
      skip_to(25);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("full_clr", bus.o_full, 1'b0);
      check("restart_addr", bus.o_address, 20'd0);

      // stop at bit 8 discards the word
      skip_to(0);
      skip_to(0);
      skip_to(8);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("stop_busy", bus.o_busy, 1'b0);
      check("stop_addr", bus.o_address, 20'd1);
      skip_to(30);
      step(1'b1, 1'b0, 1'b0);

      // stop with start in the same cycle wins
      skip_to(25);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("stop_start_busy", bus.o_busy, 1'b0);

      // reset in the middle of a word
      skip_to(30);
      step(1'b1, 1'b0, 1'b0);
      skip_to(10);
      do_reset();
      repeat (20) step(1'b0, 1'b0, 1'b0);

      // random control pulses
      for (int i = 0; i < 4000; i++) begin
         int r;
         int p;
         logic st, pa, sp;
         r  = int'($urandom_range(0, 199));
         p  = cyc % FRAME;
         st = (r < 4) || (r == 10) || (r == 12);
         pa = (r >= 4 && r < 8) || (r == 11) || (r == 12);
         sp = ((r == 8) || (r == 10) || (r == 11)) && (p != 17);
         step(st, pa, sp);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- I2S capture stage between the WM8731 ADC serial output and the SRAM write path inside the audio top level.
- Deserialises 16-bit two's-complement samples from the codec ADC stream and presents each one as an SRAM word write, with an incrementing address.
- Controlled by debounced start/pause/stop pulses from the top-level control FSM; runs entirely on the codec bit clock.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, sample width in bits.
- MAX_ADDR, 20'hFFFFF, last writable word address; recording ends after writing it.

Ports:
- i_clk  in  1  clock; driven by AUD_BCLK at top level; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lrc  in  1  ADC LR clock; 0 = left channel.
- i_data  in  1  ADC serial data, MSB first.
- i_start  in  1  one-cycle pulse: begin or resume.
- i_pause  in  1  one-cycle pulse: pause at word boundary.
- i_stop  in  1  one-cycle pulse: abort and return to idle.
- o_address  out  ADDR_W  SRAM word address of current write.
- o_data  out  DATA_W  sample to write.
- o_valid  out  1  one-cycle write strobe; o_address and o_data are valid when it is high.
- o_busy  out  1  high in any state other than IDLE.
- o_full  out  1  memory-full flag; sticky until the next start.
- o_last_addr  out  ADDR_W  address of the last completed write.

Behaviour:
- Reset state:
  - State IDLE.
  - o_address = 0, o_data = 0, o_last_addr = 0.
  - o_valid = 0, o_busy = 0, o_full = 0.
  - lrc_d = 1.
- Edge detect: lrc_d is a registered copy of i_lrc. The capture edge is the cycle k in which lrc_d = 1 and i_lrc = 0. That cycle is the I2S one-bit delay slot and is not sampled.
- States: IDLE, WAIT_EDGE, SHIFT, WRITE, PAUSED.
  - IDLE: on i_start, set o_address = 0, clear o_full, go to WAIT_EDGE.
  - WAIT_EDGE: on the capture edge, clear the bit counter and go to SHIFT.
  - SHIFT: sample i_data on cycles k+1 through k+16, shifting left (MSB first). After the 16th bit, go to WRITE.
  - WRITE (cycle k+17):
    - o_data = captured word, o_valid = 1 for exactly this cycle.
    - o_last_addr is set to o_address.
    - If o_address == MAX_ADDR: set o_full = 1 and go to IDLE; o_address holds.
    - Otherwise: o_address increments on the next cycle. Go to PAUSED if a pause is pending, else WAIT_EDGE.
  - PAUSED: o_busy stays 1. On i_start, go to WAIT_EDGE with o_address kept (resume).
- Pause: i_pause in WAIT_EDGE goes to PAUSED immediately. In SHIFT or WRITE it sets a pending flag, so the current word completes and is written first. Ignored in IDLE and PAUSED.
- Stop: i_stop in any state goes to IDLE next cycle. A partial word is discarded with no o_valid. o_address and o_last_addr hold their values; the pending flag is cleared.
- Priority when pulses coincide: stop > pause > start.
- i_start in WAIT_EDGE, SHIFT or WRITE is ignored.
- o_data holds its last value between writes.
- Asserting i_rst_n low mid-word returns everything to reset values at once; there is no partial write.

Optional Feature:
- Macro: AUD_REC_STEREO_EN.
- Defined:
  - The rising LRC edge (lrc_d = 0, i_lrc = 1) also starts a capture, for the right channel.
  - Left and right samples are written to consecutive addresses, left at even and right at odd.
  - Pause is applied only after a right-channel write.
  - Full is checked on every write.
  - Entry from IDLE or PAUSED waits for a falling edge, so the first word written is always left.
- Undefined: left channel only, as described above.

Test Plan:
- Start, then send left words 16'hA5C3 and 16'h8001 → o_valid at k+17 of each frame; writes (addr 0, A5C3) then (addr 1, 8001); right-channel data ignored; o_last_addr = 1.
- Pause mid-SHIFT of the third word, then start two frames later → third word written at addr 2, then PAUSED with no writes; after resume the next word goes to addr 3.
- Stop at bit 8 of a word → no o_valid; o_busy = 0 next cycle; o_address holds 2. A subsequent start writes the next word to addr 0.
- MAX_ADDR = 3, record 5 frames → writes at addrs 0–3 only; o_full = 1 and o_busy = 0 after the addr-3 write; o_full clears on the next start.
- Same-cycle stop and start in WAIT_EDGE → IDLE. Reset asserted during SHIFT → all outputs at reset values, no write.
- With AUD_REC_STEREO_EN, L = 16'h1111 and R = 16'h2222 → writes (0, 1111) and (1, 2222); pause asserted during left is applied only after the right write.
